// File: rtl/w_mem_responder.sv
// W-bus target endpoint: word-addressed RAM answered with a one-cycle W_ACK
// after a programmable number of wait states, claiming one 256 MB region.
module w_mem_responder #(
  parameter logic [3:0]  BASE_NIBBLE = 4'h0,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        W_CLK,
  input  logic        W_RST,
  input  logic        W_STB,
  input  logic        W_WRITE,
  input  logic [31:0] W_ADDR,
  input  logic [31:0] W_DATA_O,
  output logic [31:0] W_DATA_I,
  output logic        W_ACK
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_END
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [DW-1:0]   mem_q [DEPTH];

  logic            sel;
  logic            acc;
  logic [AW-1:0]   acc_idx;
  logic            acc_we;
  logic [DW-1:0]   acc_wdata;
  logic            mem_we;
  logic            unused_addr;

  // Only the word index and the region nibble of the address are decoded.
  assign unused_addr = ^{W_ADDR[27:AW+2], W_ADDR[1:0]};

  // Next-state, request capture and the RAM access issued on the edge into ACK.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    acc       = 1'b0;
    acc_idx   = idx_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    sel       = W_STB && (W_ADDR[31:28] == BASE_NIBBLE);

    unique case (state_q)
      ST_IDLE: begin
        if (sel) begin
          idx_d   = W_ADDR[AW+1:2];
          we_d    = W_WRITE;
          wdata_d = W_DATA_O;
          cnt_d   = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            // No wait states: the access uses the live bus values at accept.
            state_d   = ST_ACK;
            acc       = 1'b1;
            acc_idx   = W_ADDR[AW+1:2];
            acc_we    = W_WRITE;
            acc_wdata = W_DATA_O;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!W_STB) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= CW'(1)) begin
          state_d = ST_ACK;
          cnt_d   = '0;
          acc     = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_END;
      end
      ST_END: begin
        // Initiator drop-out window: the strobe is deliberately ignored here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (acc) begin
      ack_d = 1'b1;
      if (!acc_we) begin
        rdata_d = mem_q[acc_idx];
      end
    end
    mem_we = acc && acc_we && !W_RST;
  end

  // Control and output registers; reset wins over any in-flight access.
  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM storage, intentionally not reset.
  always_ff @(posedge W_CLK) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign W_ACK    = ack_q;
  assign W_DATA_I = rdata_q;

endmodule

// File: doc/w_mem_responder.md
Name: w_mem_responder

Overview:
- Target-side endpoint of the CPU W bus: answers the read/write requests that the CPU-side bus initiator drives onto W_ADDR/W_WRITE/W_DATA_O.
- Holds a word-addressed on-chip RAM and answers each accepted request with a one-cycle W_ACK after a programmable number of wait states.
- Claims only its own 256 MB region, so several responders can share one W bus.
- Includes a recovery state so that a registered initiator, which drops its strobe one cycle after seeing W_ACK, is never double-served.

Parameters:
- BASE_NIBBLE, 4'h0, value of W_ADDR[31:28] that selects this responder.
- AW, 10, word-address width; RAM depth is 2**AW 32-bit words.
- WAIT_STATES, 0, extra cycles inserted between accept and W_ACK (0..15).

Ports:
- W_CLK  input  1  bus clock; the only clock in the block.
- W_RST  input  1  reset, synchronous to W_CLK, active-high.
- W_STB  input  1  request valid from initiator; held with ADDR/WRITE/DATA_O until W_ACK.
- W_WRITE  input  1  1 = write, 0 = read.
- W_ADDR  input  32  byte address; bits [AW+1:2] index the RAM, bits [1:0] are ignored.
- W_DATA_O  input  32  write data from the initiator.
- W_DATA_I  output  32  read data to the initiator.
- W_ACK  output  1  one-cycle completion pulse.

Behaviour:
- All state changes on posedge W_CLK. W_RST has priority over every other input.
- Reset values: W_ACK=0, W_DATA_I=0, state=IDLE, wait counter=0. RAM contents are not reset.
- sel = W_STB && (W_ADDR[31:28] == BASE_NIBBLE).
- FSM states: IDLE, WAIT, ACK, END.
- IDLE:
  - If sel: latch word index, W_WRITE and W_DATA_O; load counter with WAIT_STATES.
  - Go to ACK if WAIT_STATES==0, else go to WAIT.
  - If !sel: stay in IDLE, W_ACK=0.
- WAIT:
  - If W_STB==0: abort, return to IDLE, no W_ACK, no RAM write.
  - Else decrement counter; go to ACK when it reaches 1.
- ACK (W_ACK=1 for exactly this one cycle):
  - Write: RAM[idx] <= latched data at the edge entering ACK; W_DATA_I unchanged.
  - Read: W_DATA_I <= RAM[idx], valid in the same cycle W_ACK is high, and held afterwards until the next read ACK.
  - Next state is always END.
- END: W_ACK=0; W_STB is ignored for this one cycle (initiator drop-out window); go to IDLE.
- Latency: W_ACK is high in cycle N+1+WAIT_STATES when sel is sampled at edge N. Minimum spacing between back-to-back accepts is WAIT_STATES+3 cycles.
- Inputs are sampled only at accept. Changes to W_ADDR/W_DATA_O/W_WRITE after accept have no effect.
- Unselected nibble: never acked, never written; W_DATA_I holds its value.
- Addresses above the RAM depth within the region alias modulo 2**AW words.
- Read-after-write to the same word returns the new data (write completes before END; next accept is at least 2 cycles later).
- Reset mid-operation (WAIT or ACK): next cycle IDLE, W_ACK=0, W_DATA_I=0. A write not yet reached ACK is discarded. A write whose ACK edge coincides with W_RST is also discarded (reset priority).
- W_STB held high continuously: after END, a fresh request is accepted in IDLE.

Test Plan:
- WAIT_STATES=0, write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> W_ACK 1 cycle after each accept; read returns 0xDEADBEEF; W_ACK width exactly 1.
- WAIT_STATES=3, read 0x0000_0004 after writing 0x12345678 -> W_ACK exactly 4 cycles after accept with W_DATA_I=0x12345678; no W_ACK in cycles 1-3.
- BASE_NIBBLE=4'h2, strobe W_ADDR=0x3000_0000 for 10 cycles -> W_ACK never asserts; W_DATA_I unchanged. Then W_ADDR=0x2000_0000 -> acked.
- WAIT_STATES=4, write 0xAAAA5555 to word 7, drop W_STB after 2 cycles, then read word 7 -> no W_ACK for the aborted write; read returns the prior contents of word 7.
- W_STB held high across two reads of words 1 and 2 (values 0x11, 0x22) -> exactly two W_ACK pulses separated by END; data 0x11 then 0x22; no duplicate ACK.
- W_RST asserted in WAIT during a write of 0xFFFF0000 to word 3 -> next cycle W_ACK=0, W_DATA_I=0; a subsequent read of word 3 shows the value written before the aborted write.
